refresh_sched: RTL

REFRESH_SCHED -- requirements
Module: refresh_sched

---
 rtl/refresh_sched_if.sv | 26 ++
 rtl/refresh_sched.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/refresh_sched_if.sv
// Refresh scheduler interface: groups the controller-side handshake and
// status signals of the SDRAM auto-refresh scheduler.
//   master : scheduler side (samples enable/busy/ref_done, drives status)
//   slave  : controller / sequence-generator side
interface refresh_sched_if;
   logic       enable;     // SDRAM init complete; refresh timing active
   logic       busy;       // controller mid-access; no refresh may start
   logic       ref_done;   // one-cycle completion pulse from sequence generator
   logic       ref_start;  // one-cycle start pulse to sequence generator
   logic       ref_req;    // refresh obligations outstanding
   logic       urgent;     // obligation backlog full
   logic       ref_active; // refresh sequence in progress
   logic [3:0] pend_cnt;   // outstanding refresh obligations
   logic       err_ovf;    // sticky: a refresh obligation was lost
   logic       err_tmo;    // sticky: ref_done did not arrive in time

   modport master (
      input  enable, busy, ref_done,
      output ref_start, ref_req, urgent, ref_active, pend_cnt, err_ovf, err_tmo
   );

   modport slave (
      output enable, busy, ref_done,
      input  ref_start, ref_req, urgent, ref_active, pend_cnt, err_ovf, err_tmo
   );
endinterface

// File: rtl/refresh_sched.sv
// SDRAM auto-refresh scheduler. Generates a refresh obligation every
// REF_INTERVAL enabled cycles, queues up to MAX_PEND of them, and launches
// one auto-refresh sequence at a time when the controller is idle, guarded
// by a TIMEOUT-cycle completion watchdog.
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : refresh_sched_if.master (enable, busy, ref_done in;
//           ref_start, ref_req, urgent, ref_active, pend_cnt, err_ovf, err_tmo out)
module refresh_sched #(
   parameter int unsigned REF_INTERVAL = 781,
   parameter int unsigned MAX_PEND     = 8,
   parameter int unsigned TIMEOUT      = 16
) (
   input  logic             clk,
   input  logic             n_rst,
   refresh_sched_if.master  bus
);

   localparam int unsigned IW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
   localparam int unsigned WW = $clog2(TIMEOUT + 1);
   localparam int unsigned PW = 4;

   localparam logic [IW-1:0] IVL_LAST  = IW'(REF_INTERVAL - 1);
   localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
   localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PEND);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [IW-1:0]   ivl_cnt;
   logic [WW-1:0]   wdog, wdog_nx;
   logic [PW-1:0]   pend, pend_nx;
   logic            tick;
   logic            done_acc;
   logic            tmo_hit;
   logic            ovf_set;

   logic            ref_start_q;
   logic            ref_req_q;
   logic            urgent_q;
   logic            ref_active_q;
   logic            err_ovf_q;
   logic            err_tmo_q;

   // Obligation tick on the last count of each enabled interval
   assign tick = bus.enable && (ivl_cnt == IVL_LAST);

   // Interval counter: held at 0 while disabled, wraps after REF_INTERVAL counts
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ivl_cnt <= '0;
      end else if (!bus.enable || tick) begin
         ivl_cnt <= '0;
      end else begin
         ivl_cnt <= ivl_cnt + 1'b1;
      end
   end

   // Next state, watchdog and backlog update
   always_comb begin
      state_nx = state;
      wdog_nx  = wdog;
      pend_nx  = pend;
      done_acc = 1'b0;
      tmo_hit  = 1'b0;
      ovf_set  = 1'b0;

      case (state)
         IDLE: begin
            if ((pend != '0) && !bus.busy && bus.enable) begin
               state_nx = START;
            end
         end
         START: begin
            wdog_nx  = '0;
            state_nx = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (bus.ref_done) begin
               done_acc = 1'b1;
               state_nx = IDLE;
            end else if (wdog == WDOG_LAST) begin
               tmo_hit  = 1'b1;
               wdog_nx  = '0;
               state_nx = IDLE;
            end else begin
               wdog_nx = wdog + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      // A tick and a completion in the same cycle cancel out
      if (tick && !done_acc) begin
         if (pend == PEND_MAX) begin
            ovf_set = 1'b1;
         end else begin
            pend_nx = pend + 1'b1;
         end
      end else if (done_acc && !tick && (pend != '0)) begin
         pend_nx = pend - 1'b1;
      end
   end

   // State, backlog, sticky errors and registered status outputs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= IDLE;
         wdog         <= '0;
         pend         <= '0;
         err_ovf_q    <= 1'b0;
         err_tmo_q    <= 1'b0;
         ref_start_q  <= 1'b0;
         ref_req_q    <= 1'b0;
         urgent_q     <= 1'b0;
         ref_active_q <= 1'b0;
      end else begin
         state        <= state_nx;
         wdog         <= wdog_nx;
         pend         <= pend_nx;
         err_ovf_q    <= err_ovf_q | ovf_set;
         err_tmo_q    <= err_tmo_q | tmo_hit;
         // Status flops track the next state so they line up with state/pend
         ref_start_q  <= (state_nx == START);
         ref_active_q <= (state_nx != IDLE);
         ref_req_q    <= (pend_nx != '0);
         urgent_q     <= (pend_nx == PEND_MAX);
      end
   end

   assign bus.ref_start  = ref_start_q;
   assign bus.ref_req    = ref_req_q;
   assign bus.urgent     = urgent_q;
   assign bus.ref_active = ref_active_q;
   assign bus.pend_cnt   = pend;
   assign bus.err_ovf    = err_ovf_q;
   assign bus.err_tmo    = err_tmo_q;

endmodule
